// File: rtl/pipe_scoreboard_if.sv
// rtl/pipe_scoreboard_if.sv - decode-side issue/hazard bundle for pipe_scoreboard
//
// Purpose: groups the decode-stage issue signals and the scoreboard's hazard
// outputs into one bundle.
//   master modport (decode): drives issue_* and flush, receives stall/fwd/count
//   slave modport (scoreboard): the reverse
// Signals:
//   issue_valid            instruction presented at decode
//   issue_rs, issue_rt     source register indices (REG_AW)
//   issue_rs_used/rt_used  matching source is actually read
//   issue_wr_en, issue_rd  destination write enable / index
//   issue_is_load          instruction is a memory load
//   flush                  kill the issuing instruction and the stage-1 entry
//   stall                  hold fetch/decode this cycle
//   fwd_a, fwd_b           forwarding source for rs/rt (0 = regfile, k = stage k)
//   stall_cnt              saturating count of stalled cycles (CNT_W)
interface pipe_scoreboard_if #(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int CNT_W  = 16
);
  localparam int FW = $clog2(DEPTH + 1);

  logic              issue_valid;
  logic [REG_AW-1:0] issue_rs;
  logic [REG_AW-1:0] issue_rt;
  logic              issue_rs_used;
  logic              issue_rt_used;
  logic              issue_wr_en;
  logic [REG_AW-1:0] issue_rd;
  logic              issue_is_load;
  logic              flush;
  logic              stall;
  logic [FW-1:0]     fwd_a;
  logic [FW-1:0]     fwd_b;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output issue_valid, issue_rs, issue_rt, issue_rs_used, issue_rt_used,
    output issue_wr_en, issue_rd, issue_is_load, flush,
    input  stall, fwd_a, fwd_b, stall_cnt
  );

  modport slave (
    input  issue_valid, issue_rs, issue_rt, issue_rs_used, issue_rt_used,
    input  issue_wr_en, issue_rd, issue_is_load, flush,
    output stall, fwd_a, fwd_b, stall_cnt
  );
endinterface

// File: rtl/pipe_scoreboard.sv
// rtl/pipe_scoreboard.sv - in-order pipeline register scoreboard with stall/forward control
//
// Purpose: tracks destination registers of instructions in flight (stages
// 1..DEPTH after issue) and decides, for the instruction at decode, whether
// it must stall or which stage its sources forward from.
// Ports:
//   clk   single clock, rising edge
//   rst   synchronous active-high reset
//   sb    pipe_scoreboard_if.slave (issue inputs, flush, stall, fwd_a/b, stall_cnt)
// Configuration macro: PIPE_SCOREBOARD_FORWARD_EN
//   defined   : stall only on load-use against stage 1; other hazards forward
//   undefined : stall on any hazard in stages 1..DEPTH-1; fwd_a/fwd_b tied 0
module pipe_scoreboard #(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int CNT_W  = 16
) (
  input logic            clk,
  input logic            rst,
  pipe_scoreboard_if.slave sb
);
  localparam int FW = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // The stage-DEPTH entry is invisible to hazard logic (the register file
  // writes through), so only stages 1..DEPTH-1 are held; the entry leaving
  // stage DEPTH-1 simply retires through the untracked last stage.
  logic [DEPTH-1:1] valid_q;
  logic [REG_AW-1:0] rd_q [1:DEPTH-1];
`ifdef PIPE_SCOREBOARD_FORWARD_EN
  // Only a stage-1 load can create a stall, so deeper load flags are not kept.
  logic load_s1_q;
`endif
  logic [CNT_W-1:0] cnt_q;

  logic [DEPTH-1:1] match_a;
  logic [DEPTH-1:1] match_b;
  logic             issue_ok;
  logic             stall_c;
  logic [FW-1:0]    fwd_a_c;
  logic [FW-1:0]    fwd_b_c;

  // An instruction can only stall while it is actually presented and not killed.
  assign issue_ok = sb.issue_valid & ~sb.flush;

  always_comb begin
    match_a = '0;
    match_b = '0;
    for (int k = 1; k <= DEPTH - 1; k++) begin
      match_a[k] = valid_q[k] && (rd_q[k] == sb.issue_rs) && sb.issue_rs_used &&
                   (sb.issue_rs != '0);
      match_b[k] = valid_q[k] && (rd_q[k] == sb.issue_rt) && sb.issue_rt_used &&
                   (sb.issue_rt != '0);
    end
  end

`ifdef PIPE_SCOREBOARD_FORWARD_EN
  always_comb begin
    stall_c = issue_ok & load_s1_q & (match_a[1] | match_b[1]);
    fwd_a_c = '0;
    fwd_b_c = '0;
    // Scan oldest to youngest so the youngest (lowest stage) producer wins.
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (match_a[k]) fwd_a_c = FW'(k);
      if (match_b[k]) fwd_b_c = FW'(k);
    end
  end
`else
  always_comb begin
    stall_c = issue_ok & ((|match_a) | (|match_b));
    fwd_a_c = '0;
    fwd_b_c = '0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      cnt_q   <= '0;
`ifdef PIPE_SCOREBOARD_FORWARD_EN
      load_s1_q <= 1'b0;
`endif
    end else begin
      // Stage 1 takes the issuing instruction only when it really leaves
      // decode; writes to r0 are never tracked.
      valid_q[1] <= issue_ok & ~stall_c & sb.issue_wr_en & (sb.issue_rd != '0);
      rd_q[1]    <= sb.issue_rd;
`ifdef PIPE_SCOREBOARD_FORWARD_EN
      load_s1_q  <= sb.issue_is_load;
`endif
      // Flush also kills the entry moving from stage 1 into stage 2.
      for (int k = 2; k <= DEPTH - 1; k++) begin
        valid_q[k] <= valid_q[k-1] & ~(sb.flush & (k == 2));
        rd_q[k]    <= rd_q[k-1];
      end
      if (stall_c && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign sb.stall     = stall_c;
  assign sb.fwd_a     = fwd_a_c;
  assign sb.fwd_b     = fwd_b_c;
  assign sb.stall_cnt = cnt_q;
endmodule

// File: tb/tb_pipe_scoreboard.sv
// tb/tb_pipe_scoreboard.sv - directed self-checking bench for pipe_scoreboard
module tb_pipe_scoreboard;
`ifdef PIPE_SCOREBOARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pipe_scoreboard_if #(.REG_AW(5), .DEPTH(3), .CNT_W(2)) sb_if ();

  pipe_scoreboard #(.REG_AW(5), .DEPTH(3), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if.slave)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int rs, input bit rsu, input int rt, input bit rtu,
                       input bit we, input int rd, input bit ld, input bit fl);
    sb_if.issue_valid   = v;
    sb_if.issue_rs      = 5'(rs);
    sb_if.issue_rs_used = rsu;
    sb_if.issue_rt      = 5'(rt);
    sb_if.issue_rt_used = rtu;
    sb_if.issue_wr_en   = we;
    sb_if.issue_rd      = 5'(rd);
    sb_if.issue_is_load = ld;
    sb_if.flush         = fl;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    idle();
    tick();
    tick();
    // reset state, with a would-be dependent reader presented
    drive(1, 5, 1, 6, 1, 1, 5, 0, 0);
    check("rst_stall", int'(sb_if.stall), 0);
    check("rst_fwd_a", int'(sb_if.fwd_a), 0);
    check("rst_cnt", int'(sb_if.stall_cnt), 0);

    // add r5 then reader of r5
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 5, 0, 0);
    tick();
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
    check("raw1_stall", int'(sb_if.stall), FWD ? 0 : 1);
    check("raw1_fwd_a", int'(sb_if.fwd_a), FWD ? 1 : 0);
    tick();
    check("raw2_stall", int'(sb_if.stall), FWD ? 0 : 1);
    check("raw2_fwd_a", int'(sb_if.fwd_a), FWD ? 2 : 0);
    tick();
    check("raw3_stall", int'(sb_if.stall), 0);
    check("raw3_fwd_a", int'(sb_if.fwd_a), 0);
    check("raw3_cnt", int'(sb_if.stall_cnt), FWD ? 0 : 2);

    // load r7 then reader of rt=7
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 7, 1, 0);
    tick();
    drive(1, 0, 0, 7, 1, 0, 0, 0, 0);
    check("lu1_stall", int'(sb_if.stall), 1);
    check("lu1_fwd_b", int'(sb_if.fwd_b), FWD ? 1 : 0);
    tick();
    check("lu2_stall", int'(sb_if.stall), FWD ? 0 : 1);
    check("lu2_fwd_b", int'(sb_if.fwd_b), FWD ? 2 : 0);
    check("lu2_cnt", int'(sb_if.stall_cnt), 1);
    tick();
    check("lu3_stall", int'(sb_if.stall), 0);
    check("lu3_cnt", int'(sb_if.stall_cnt), FWD ? 1 : 2);

    // writes to r0 are never hazards
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 0, 1, 0);
    tick();
    drive(1, 0, 1, 0, 1, 0, 0, 0, 0);
    check("r0_stall", int'(sb_if.stall), 0);
    check("r0_fwd_a", int'(sb_if.fwd_a), 0);

    // two producers of r6: the younger one wins
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 6, 0, 0);
    tick();
    drive(1, 6, 0, 6, 0, 1, 6, 0, 0);
    check("yw_unused_stall", int'(sb_if.stall), 0);
    tick();
    drive(1, 6, 1, 6, 1, 0, 0, 0, 0);
    check("yw_stall", int'(sb_if.stall), FWD ? 0 : 1);
    check("yw_fwd_a", int'(sb_if.fwd_a), FWD ? 1 : 0);
    check("yw_fwd_b", int'(sb_if.fwd_b), FWD ? 1 : 0);
    drive(0, 6, 1, 6, 1, 0, 0, 0, 0);
    check("novalid_stall", int'(sb_if.stall), 0);

    // producer at stage DEPTH is never hazardous
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 8, 0, 0);
    tick();
    idle();
    tick();
    tick();
    drive(1, 8, 1, 8, 1, 0, 0, 0, 0);
    check("wb_stall", int'(sb_if.stall), 0);
    check("wb_fwd_a", int'(sb_if.fwd_a), 0);

    // flush kills the stage-1 load and the issuing writer of r11
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 4, 1, 0);
    tick();
    drive(1, 4, 1, 0, 0, 1, 11, 0, 1);
    check("fl_stall", int'(sb_if.stall), 0);
    tick();
    drive(1, 4, 1, 11, 1, 0, 0, 0, 0);
    check("fl_next_stall", int'(sb_if.stall), 0);
    check("fl_next_fwd_a", int'(sb_if.fwd_a), 0);
    check("fl_next_fwd_b", int'(sb_if.fwd_b), 0);

    // repeated self-dependent loads: counter saturates at 3, then reset mid-stall
    do_reset();
    drive(1, 9, 1, 0, 0, 1, 9, 1, 0);
    check("sat_c0_stall", int'(sb_if.stall), 0);
    for (int i = 0; i < 11; i++) tick();
    check("sat_stall", int'(sb_if.stall), 1);
    check("sat_cnt", int'(sb_if.stall_cnt), 3);
    rst = 1'b1;
    tick();
    check("mid_rst_cnt", int'(sb_if.stall_cnt), 0);
    check("mid_rst_stall", int'(sb_if.stall), 0);
    check("mid_rst_fwd_a", int'(sb_if.fwd_a), 0);
    rst = 1'b0;
    #1;
    check("post_rst_stall", int'(sb_if.stall), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_scoreboard.md
PIPE_SCOREBOARD -- requirements
Module: pipe_scoreboard

Interface
REQ-001 SHALL have parameter REG_AW, default 5: register-index width (2^REG_AW architectural registers).
REQ-002 SHALL have parameter DEPTH, default 3: pipeline stages after issue, numbered 1 to DEPTH (1 = EX, DEPTH = WB); legal range 2 to 8.
REQ-003 SHALL have parameter CNT_W, default 16: stall-counter width.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port issue_valid, input, 1: an instruction is presented at decode.
REQ-007 SHALL have ports issue_rs and issue_rt, input, REG_AW each: source register indices.
REQ-008 SHALL have ports issue_rs_used and issue_rt_used, input, 1 each: the matching source is actually read.
REQ-009 SHALL have port issue_wr_en, input, 1: the instruction writes a register.
REQ-010 SHALL have port issue_rd, input, REG_AW: destination register index.
REQ-011 SHALL have port issue_is_load, input, 1: the instruction is a memory load.
REQ-012 SHALL have port flush, input, 1: kill the issuing instruction and the stage-1 entry.
REQ-013 SHALL have port stall, output, 1: hold fetch/decode this cycle.
REQ-014 SHALL have ports fwd_a and fwd_b, output, clog2(DEPTH+1) each: forwarding source for rs/rt (0 = register file, k = stage k).
REQ-015 SHALL have port stall_cnt, output, CNT_W: count of stalled cycles.

Function
REQ-016 SHALL hold a DEPTH-entry shift register; each entry is {valid, rd, is_load}; all entries advance one stage every cycle, and the stage-DEPTH entry retires.
REQ-017 SHALL load stage 1 with {issue_wr_en and rd!=0, issue_rd, issue_is_load} when issue_valid=1, stall=0 and flush=0; otherwise stage 1 SHALL receive a bubble (valid=0).
REQ-018 SHALL, when flush=1, also clear the entry leaving stage 1 so that stage 2 receives a bubble; stages 2 to DEPTH SHALL be unaffected.
REQ-019 SHALL define a source match for stage k as: entry valid, entry rd equal to the source index, source used, and source index not 0.
REQ-020 SHALL treat the stage-DEPTH entry as never hazardous, because the register file is write-through.
REQ-021 SHALL drive fwd_a and fwd_b to the lowest matching stage k in 1 to DEPTH-1 (the youngest producer wins), else 0; this logic SHALL be combinational from the current inputs and state.
REQ-022 SHALL drive stall combinationally; stall SHALL be 0 whenever issue_valid=0 or flush=1.
REQ-023 SHALL increment stall_cnt by 1 each cycle stall=1 and saturate at 2^CNT_W-1 with no wrap.
REQ-024 SHALL behave so that a stalled instruction re-evaluates next cycle against the advanced entries, with no internal latching of issue inputs.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, clear every entry valid bit, zero stall_cnt, and take priority over flush and issue.
REQ-026 SHALL, during and after reset until a new issue, drive stall=0 and fwd_a=fwd_b=0 given the inputs.

Configuration
REQ-027 SHALL with macro PIPE_SCOREBOARD_FORWARD_EN defined: assert stall only when a stage-1 entry with is_load=1 matches a used source (load-use, 1 bubble); all other dependencies resolve through fwd_a/fwd_b.
REQ-028 SHALL with PIPE_SCOREBOARD_FORWARD_EN undefined: assert stall on any match in stages 1 to DEPTH-1, and tie fwd_a and fwd_b to 0.

Verification
REQ-029 SHALL cover, with FORWARD_EN and DEPTH=3, issue add rd=5 then add rs=5 on the next cycle: expect stall=0, fwd_a=1; one cycle later expect fwd_a=2.
REQ-030 SHALL cover, with FORWARD_EN, issue load rd=7 then rt=7 used: expect stall=1 for exactly 1 cycle, then fwd_b=2, stall_cnt=1.
REQ-031 SHALL cover, with FORWARD_EN undefined and DEPTH=3, issue add rd=3 then rs=3: expect stall=1 for 2 cycles, then fwd_a=0, stall_cnt=2.
REQ-032 SHALL cover writes to rd=0 followed by a reader of rs=0: expect stall=0 and fwd_a=0 in both configurations.
REQ-033 SHALL cover issue load rd=4, then assert flush with a dependent rs=4 presented: expect stall=0 that cycle, and stage 2 empty the next cycle (no later forward from the load).
REQ-034 SHALL cover stall_cnt at saturation with CNT_W=2 after 5 stalled cycles: expect 3; then rst=1 mid-stall: expect stall_cnt=0 and all entries invalid the next cycle.
